ps2_mouse_byte_receiver: RTL and testbench
==========================================

# ps2_mouse_byte_receiver

Deserialises the PS/2 mouse line (PS2_CLK/PS2_DAT) into validated bytes and tags each byte with its position in the 3-byte mouse movement packet. It sits directly upstream of the mouse packet decoder, which consumes `received_data`/`received_data_en`/`byte_index` and turns them into cursor position and button state. Receive-only: the host-to-device command path lives elsewhere.

## Interface
- `TIMEOUT_CYCLES`, default 100000 (2 ms at 50 MHz): max `clk` cycles between PS/2 falling edges inside a frame.
- `clk`  in  1  system clock; the only clock.
- `reset`  in  1  synchronous, active-high reset.
- `PS2_CLK`  in  1  raw PS/2 clock pin (asynchronous).
- `PS2_DAT`  in  1  raw PS/2 data pin (asynchronous).
- `received_data`  out  8  last accepted byte; holds until the next accepted byte.
- `received_data_en`  out  1  one-cycle pulse: `received_data` is new.
- `byte_index`  out  2  packet position of `received_data` (0, 1, 2); valid with, and held after, `received_data_en`.
- `frame_error`  out  1  one-cycle pulse on parity, stop-bit, timeout or packet-alignment error.
- `busy`  out  1  high whenever FSM is not in IDLE.

## Operation
- Input conditioning: `PS2_CLK` and `PS2_DAT` each pass through a 2-FF synchroniser; a third register on the synced clock gives `ps2_clk_negedge` = prev 1 and current 0. All bit sampling uses synced data on `ps2_clk_negedge` cycles only.
- Frame: start(0), 8 data bits LSB first, odd parity, stop(1).
- FSM states and transitions (evaluated only on `ps2_clk_negedge` unless stated):
  - IDLE: data 0 -> DATA_IN; data 1 -> stay IDLE (no error).
  - DATA_IN: shift `{data, shift[7:1]}`, bit counter +1; after 8th bit -> PARITY_IN.
  - PARITY_IN: capture parity bit -> STOP_IN.
  - STOP_IN: check stop = 1 and XOR(shift, parity) = 1; pass -> byte accept; fail -> frame_error; either way -> IDLE.
  - Any state except IDLE: timeout counter reaching `TIMEOUT_CYCLES` -> IDLE, frame_error. Counter clears on every `ps2_clk_negedge` and in IDLE.
- Byte accept / packet alignment, internal `next_index` (0..2):
  - `next_index` = 0 and byte bit 3 = 0: byte discarded, frame_error pulses, `next_index` stays 0 (resync on mouse status byte).
  - Otherwise: `received_data` <= byte, `byte_index` <= `next_index`, `received_data_en` pulses, `next_index` <= `next_index` = 2 ? 0 : +1.
- Any frame_error (parity, stop, timeout, alignment) resets `next_index` to 0.
- Reset: FSM IDLE; `received_data` 8'h00, `received_data_en` 0, `byte_index` 0, `frame_error` 0, `busy` 0; shift register, bit counter, timeout counter, `next_index` all 0; synchroniser stages 1 (idle line).

## Timing
- Pin-to-edge latency: `PS2_CLK` fall registered at cycle t -> `ps2_clk_negedge` high in cycle t+2 (one cycle wide).
- `received_data_en`, `received_data`, `byte_index` and `frame_error` update on the clock edge consuming the 11th negedge pulse; pulses high exactly one cycle later, never two consecutive cycles.
- `received_data_en` and `frame_error` are mutually exclusive in any cycle.
- Timeout: frame_error asserts in the cycle after the counter equals `TIMEOUT_CYCLES`; FSM in IDLE that same cycle.
- `busy` rises the cycle after the start-bit edge is consumed; falls with the IDLE return.
- Reset mid-frame: partial byte dropped, no pulse on either output; next frame is received normally.
- Glitch-free PS/2 clock is required (10-16.7 kHz); no additional debounce.

## Test plan
- Reset then frames 0x08, 0x05, 0xFB (valid parity/stop) -> three `received_data_en` pulses with data/index 0x08/0, 0x05/1, 0xFB/2; `frame_error` never high.
- Frame 0x08 with parity bit inverted -> `frame_error` one pulse, no `received_data_en`; following 0x09, 0x01, 0x02 -> indices 0, 1, 2.
- Frames 0x08, 0x10, then stall `PS2_CLK` high after 4 data bits for `TIMEOUT_CYCLES`+5 cycles -> `frame_error` pulse, `busy` 0; next 0x18 reported with `byte_index` 0.
- First byte 0x00 (bit 3 clear) -> discarded with `frame_error`; next 0x28 -> `received_data_en`, index 0.
- Frame with stop bit 0 -> `frame_error`, `received_data` keeps previous value.
- Assert `reset` during bit 5 of a frame, release, send 0x08 -> no spurious pulses, 0x08 reported with index 0.

Source files
------------

// File: rtl/ps2_mouse_byte_receiver.sv
// PS/2 mouse byte receiver.
// Turns the raw PS/2 clock and data pins into validated bytes. Each byte is
// tagged with its position in the 3-byte mouse movement packet.
// Only the device-to-host direction is handled here.
module ps2_mouse_byte_receiver #(
   parameter int TIMEOUT_CYCLES = 100000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       PS2_CLK,
   input  logic       PS2_DAT,
   output logic [7:0] received_data,
   output logic       received_data_en,
   output logic [1:0] byte_index,
   output logic       frame_error,
   output logic       busy
);

   // The counter is wide enough to hold TIMEOUT_CYCLES itself.
   localparam int CW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CW-1:0] TIMEOUT_VAL = CW'(TIMEOUT_CYCLES);

   typedef enum logic [1:0] {
      IDLE,
      DATA_IN,
      PARITY_IN,
      STOP_IN
   } state_t;

   state_t state;
   state_t state_next;

   logic          clk_meta;
   logic          clk_sync;
   logic          clk_prev;
   logic          dat_meta;
   logic          dat_sync;
   logic          ps2_clk_negedge;

   logic [7:0]    shift_reg;
   logic [2:0]    bit_cnt;
   logic          parity_bit;
   logic [CW-1:0] timeout_cnt;
   logic [1:0]    next_index;

   logic          timeout_hit;
   logic          take_byte;
   logic          take_error;

   // Two-flop synchronisers for both pins, plus a delayed copy of the clock for edge detection.
   always_ff @(posedge clk) begin
      if (reset) begin
         clk_meta <= 1'b1;
         clk_sync <= 1'b1;
         clk_prev <= 1'b1;
         dat_meta <= 1'b1;
         dat_sync <= 1'b1;
      end else begin
         clk_meta <= PS2_CLK;
         clk_sync <= clk_meta;
         clk_prev <= clk_sync;
         dat_meta <= PS2_DAT;
         dat_sync <= dat_meta;
      end
   end

   assign ps2_clk_negedge = clk_prev & ~clk_sync;
   assign timeout_hit     = (state != IDLE) && (timeout_cnt == TIMEOUT_VAL);
   assign busy            = (state != IDLE);

   // State register for the frame FSM.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic and per-frame verdict. A stalled line wins over a coincident edge.
   always_comb begin
      state_next = state;
      take_byte  = 1'b0;
      take_error = 1'b0;
      if (timeout_hit) begin
         state_next = IDLE;
         take_error = 1'b1;
      end else if (ps2_clk_negedge) begin
         case (state)
            IDLE: begin
               if (!dat_sync) begin
                  state_next = DATA_IN;
               end
            end
            DATA_IN: begin
               if (bit_cnt == 3'd7) begin
                  state_next = PARITY_IN;
               end
            end
            PARITY_IN: begin
               state_next = STOP_IN;
            end
            STOP_IN: begin
               state_next = IDLE;
               if (dat_sync && (^{shift_reg, parity_bit})) begin
                  // The first byte of a packet always has bit 3 set. Drop any byte
                  // without it so the packet framing can resync.
                  if ((next_index == 2'd0) && !shift_reg[3]) begin
                     take_error = 1'b1;
                  end else begin
                     take_byte = 1'b1;
                  end
               end else begin
                  take_error = 1'b1;
               end
            end
            default: begin
               state_next = IDLE;
            end
         endcase
      end
   end

   // Bit capture: shift data LSB first, count the data bits, then latch the parity bit.
   always_ff @(posedge clk) begin
      if (reset) begin
         shift_reg  <= 8'h00;
         bit_cnt    <= 3'd0;
         parity_bit <= 1'b0;
      end else if (state == IDLE) begin
         bit_cnt <= 3'd0;
      end else if (ps2_clk_negedge && !timeout_hit) begin
         if (state == DATA_IN) begin
            shift_reg <= {dat_sync, shift_reg[7:1]};
            bit_cnt   <= bit_cnt + 3'd1;
         end else if (state == PARITY_IN) begin
            parity_bit <= dat_sync;
         end
      end
   end

   // Inter-edge watchdog. It clears on every PS/2 falling edge, while idle, and once it fires.
   always_ff @(posedge clk) begin
      if (reset) begin
         timeout_cnt <= '0;
      end else if ((state == IDLE) || ps2_clk_negedge || timeout_hit) begin
         timeout_cnt <= '0;
      end else begin
         timeout_cnt <= timeout_cnt + CW'(1);
      end
   end

   // Output registers and packet position tracking. Any error restarts the packet.
   always_ff @(posedge clk) begin
      if (reset) begin
         received_data    <= 8'h00;
         received_data_en <= 1'b0;
         byte_index       <= 2'd0;
         frame_error      <= 1'b0;
         next_index       <= 2'd0;
      end else begin
         received_data_en <= take_byte;
         frame_error      <= take_error;
         if (take_byte) begin
            received_data <= shift_reg;
            byte_index    <= next_index;
            next_index    <= (next_index == 2'd2) ? 2'd0 : next_index + 2'd1;
         end else if (take_error) begin
            next_index <= 2'd0;
         end
      end
   end

endmodule

// File: tb/tb_ps2_mouse_byte_receiver.sv
// Self-checking bench for ps2_mouse_byte_receiver: directed scenarios, then random frames checked against a packet model.
module tb_ps2_mouse_byte_receiver;

   localparam int TIMEOUT = 200;

   logic       clk;
   logic       reset;
   logic       PS2_CLK;
   logic       PS2_DAT;
   logic [7:0] received_data;
   logic       received_data_en;
   logic [1:0] byte_index;
   logic       frame_error;
   logic       busy;

   int checks = 0;
   int errors = 0;
   int en_cnt = 0;
   int err_cnt = 0;
   logic [7:0] obs_data = 8'h00;
   logic [1:0] obs_idx = 2'd0;
   logic prev_en = 1'b0;
   logic prev_err = 1'b0;
   int half_period = 8;

   // Packet model: where the next accepted byte goes, and the last accepted byte.
   int model_idx = 0;
   logic [7:0] model_last = 8'h00;

   ps2_mouse_byte_receiver #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
      .clk(clk),
      .reset(reset),
      .PS2_CLK(PS2_CLK),
      .PS2_DAT(PS2_DAT),
      .received_data(received_data),
      .received_data_en(received_data_en),
      .byte_index(byte_index),
      .frame_error(frame_error),
      .busy(busy)
   );

   // System clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
      end
   endtask

   // Output monitor: counts pulses and checks they are single-cycle and never coincide.
   always @(negedge clk) begin
      if (received_data_en) begin
         en_cnt++;
         obs_data = received_data;
         obs_idx  = byte_index;
         checkOutput("en_err_exclusive", {31'd0, frame_error}, 32'd0);
         checkOutput("en_single_cycle", {31'd0, prev_en}, 32'd0);
      end
      if (frame_error) begin
         err_cnt++;
         checkOutput("err_single_cycle", {31'd0, prev_err}, 32'd0);
      end
      prev_en  <= received_data_en;
      prev_err <= frame_error;
   end

   task automatic waitCycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // One PS/2 bit: data changes while the clock is high, and the host samples it on the falling edge.
   task automatic ps2Bit(input logic b);
      PS2_DAT = b;
      waitCycles(half_period);
      PS2_CLK = 1'b0;
      waitCycles(half_period);
      PS2_CLK = 1'b1;
   endtask

   // Drives a complete frame. The parity and stop bits can each be corrupted.
   task automatic applyStimulus(input logic [7:0] data, input bit bad_parity, input bit bad_stop);
      logic par;
      par = ~(^data);
      if (bad_parity) par = ~par;
      ps2Bit(1'b0);
      for (int i = 0; i < 8; i++) ps2Bit(data[i]);
      ps2Bit(par);
      ps2Bit(bad_stop ? 1'b0 : 1'b1);
      PS2_DAT = 1'b1;
      waitCycles(2 * half_period + 6);
   endtask

   task automatic doReset();
      reset = 1'b1;
      waitCycles(3);
      reset = 1'b0;
      waitCycles(2);
      model_idx  = 0;
      model_last = 8'h00;
   endtask

   // Sends one frame and compares the outcome with the packet model.
   task automatic sendAndCheck(input logic [7:0] data, input bit bad_parity, input bit bad_stop);
      int en0, err0, exp_en, exp_err, exp_idx;
      en0 = en_cnt;
      err0 = err_cnt;
      exp_en = 0;
      exp_err = 0;
      exp_idx = model_idx;
      if (bad_parity || bad_stop || (model_idx == 0 && data[3] == 1'b0)) begin
         exp_err = 1;
         model_idx = 0;
      end else begin
         exp_en = 1;
         model_last = data;
         model_idx = (model_idx + 1) % 3;
      end
      applyStimulus(data, bad_parity, bad_stop);
      checkOutput("en_count", en_cnt - en0, exp_en);
      checkOutput("err_count", err_cnt - err0, exp_err);
      checkOutput("held_data", {24'd0, received_data}, {24'd0, model_last});
      if (exp_en == 1) begin
         checkOutput("pulse_data", {24'd0, obs_data}, {24'd0, data});
         checkOutput("pulse_index", {30'd0, obs_idx}, exp_idx);
         checkOutput("held_index", {30'd0, byte_index}, exp_idx);
      end
      checkOutput("busy_idle", {31'd0, busy}, 32'd0);
   endtask

   initial begin
      int en0, err0;
      logic [7:0] rd;
      reset   = 1'b1;
      PS2_CLK = 1'b1;
      PS2_DAT = 1'b1;
      waitCycles(4);
      checkOutput("reset_data", {24'd0, received_data}, 32'd0);
      checkOutput("reset_en", {31'd0, received_data_en}, 32'd0);
      checkOutput("reset_index", {30'd0, byte_index}, 32'd0);
      checkOutput("reset_err", {31'd0, frame_error}, 32'd0);
      checkOutput("reset_busy", {31'd0, busy}, 32'd0);
      doReset();

      $display("[TB] basic packet");
      sendAndCheck(8'h08, 0, 0);
      sendAndCheck(8'h05, 0, 0);
      sendAndCheck(8'hFB, 0, 0);

      $display("[TB] parity error then realign");
      sendAndCheck(8'h08, 1, 0);
      sendAndCheck(8'h09, 0, 0);
      sendAndCheck(8'h01, 0, 0);
      sendAndCheck(8'h02, 0, 0);

      $display("[TB] timeout mid-frame");
      sendAndCheck(8'h08, 0, 0);
      sendAndCheck(8'h10, 0, 0);
      en0 = en_cnt;
      err0 = err_cnt;
      ps2Bit(1'b0);
      for (int i = 0; i < 4; i++) ps2Bit(1'b1);
      checkOutput("busy_in_frame", {31'd0, busy}, 32'd1);
      waitCycles(TIMEOUT + 5 + 10);
      checkOutput("timeout_err", err_cnt - err0, 1);
      checkOutput("timeout_en", en_cnt - en0, 0);
      checkOutput("timeout_busy", {31'd0, busy}, 32'd0);
      model_idx = 0;
      sendAndCheck(8'h18, 0, 0);

      $display("[TB] alignment discard");
      doReset();
      sendAndCheck(8'h00, 0, 0);
      sendAndCheck(8'h28, 0, 0);

      $display("[TB] bad stop bit");
      sendAndCheck(8'h3C, 0, 1);

      $display("[TB] reset mid-frame");
      sendAndCheck(8'h08, 0, 0);
      en0 = en_cnt;
      err0 = err_cnt;
      rd = 8'hA5;
      ps2Bit(1'b0);
      for (int i = 0; i < 5; i++) ps2Bit(rd[i]);
      PS2_DAT = 1'b1;
      doReset();
      waitCycles(TIMEOUT + 20);
      checkOutput("midreset_en", en_cnt - en0, 0);
      checkOutput("midreset_err", err_cnt - err0, 0);
      checkOutput("midreset_data", {24'd0, received_data}, 32'd0);
      sendAndCheck(8'h08, 0, 0);

      $display("[TB] random frames");
      for (int n = 0; n < 40; n++) begin
         logic [7:0] d;
         bit bp, bs;
         d  = 8'($urandom);
         bp = ($urandom_range(0, 5) == 0);
         bs = ($urandom_range(0, 7) == 0);
         half_period = $urandom_range(5, 12);
         sendAndCheck(d, bp, bs);
      end

      $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
